// File: rtl/transport_cmd_arbiter.sv
// Arbitrates one transport command port between the session-control and audio requesters.
// Control has priority, bounded by a run limit so pending audio is never starved.
module transport_cmd_arbiter #(
    parameter int CMD_HOLD     = 5,
    parameter int BUSY_TIMEOUT = 64,
    parameter int MAX_CTRL_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_req,
    input  logic [1:0]  ctrl_cmd,
    input  logic [15:0] ctrl_data,
    output logic        ctrl_ack,
    input  logic        audio_req,
    input  logic [1:0]  audio_cmd,
    input  logic [15:0] audio_data,
    output logic        audio_ack,
    output logic [1:0]  tx_cmd,
    output logic [15:0] tx_data,
    input  logic        tx_busy,
    output logic [1:0]  active_src,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_CTRL  = 2'b01;
    localparam logic [1:0] SRC_AUDIO = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [3:0]  hold_cnt;
    logic [7:0]  timeout_cnt;
    logic [3:0]  ctrl_run;
    logic        busy_seen;
    logic        aborted;

    logic        grant_ctrl;
    logic        grant_audio;
    logic [1:0]  sel_cmd;
    logic [15:0] sel_data;
    logic        hold_done;
    logic        busy_done;
    logic        timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timeout fires on the cycle that would make the count reach BUSY_TIMEOUT,
    // so the abort lands exactly BUSY_TIMEOUT cycles after the issue starts.
    always_comb begin
        grant_ctrl  = 1'b0;
        grant_audio = 1'b0;
        sel_cmd     = audio_cmd;
        sel_data    = audio_data;
        hold_done   = (hold_cnt == 4'(CMD_HOLD - 1));
        busy_done   = busy_seen && !tx_busy;
        timeout_hit = !busy_seen && (timeout_cnt >= 8'(BUSY_TIMEOUT - 1));
        state_next  = state;
        case (state)
            IDLE: begin
                if (ctrl_req && !(audio_req && (ctrl_run == 4'(MAX_CTRL_RUN)))) begin
                    grant_ctrl = 1'b1;
                end else if (audio_req) begin
                    grant_audio = 1'b1;
                end
                if (grant_ctrl) begin
                    sel_cmd  = ctrl_cmd;
                    sel_data = ctrl_data;
                end
                if (grant_ctrl || grant_audio) begin
                    state_next = (sel_cmd == 2'b00) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (hold_done) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (busy_done || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cmd      <= 2'b00;
            tx_data     <= 16'h0000;
            active_src  <= SRC_NONE;
            hold_cnt    <= 4'd0;
            timeout_cnt <= 8'd0;
            ctrl_run    <= 4'd0;
            busy_seen   <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ctrl || grant_audio) begin
                        active_src  <= grant_ctrl ? SRC_CTRL : SRC_AUDIO;
                        hold_cnt    <= 4'd0;
                        timeout_cnt <= 8'd0;
                        busy_seen   <= 1'b0;
                        aborted     <= 1'b0;
                        if (sel_cmd != 2'b00) begin
                            tx_cmd  <= sel_cmd;
                            tx_data <= sel_data;
                        end
                        if (grant_ctrl && audio_req) begin
                            ctrl_run <= ctrl_run + 4'd1;
                        end else begin
                            ctrl_run <= 4'd0;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (tx_busy) begin
                        busy_seen <= 1'b1;
                    end
                    if (!busy_seen && (timeout_cnt != 8'hFF)) begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                    if (state == ISSUE) begin
                        hold_cnt <= hold_cnt + 4'd1;
                        if (hold_done) begin
                            tx_cmd <= 2'b00;
                        end
                    end else if (!busy_done && timeout_hit) begin
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    active_src <= SRC_NONE;
                end
                default: begin
                    active_src <= SRC_NONE;
                end
            endcase
        end
    end

    assign ctrl_ack    = (state == DONE) && (active_src == SRC_CTRL);
    assign audio_ack   = (state == DONE) && (active_src == SRC_AUDIO);
    assign timeout_err = (state == DONE) && aborted;

endmodule

// File: tb/tb_transport_cmd_arbiter.sv
// Directed self-checking bench for transport_cmd_arbiter with a simple transport busy model.
// Expected values are hand-derived from the cycle timing of each operation.
module tb_transport_cmd_arbiter;

    logic        clk;
    logic        reset;
    logic        ctrl_req;
    logic [1:0]  ctrl_cmd;
    logic [15:0] ctrl_data;
    logic        ctrl_ack;
    logic        audio_req;
    logic [1:0]  audio_cmd;
    logic [15:0] audio_data;
    logic        audio_ack;
    logic [1:0]  tx_cmd;
    logic [15:0] tx_data;
    logic        tx_busy;
    logic [1:0]  active_src;
    logic        timeout_err;

    int errors;
    int checks;
    int n_ctrl_ack;
    int n_audio_ack;
    int n_timeout;
    int n_both;
    logic [1:0] grant_log[$];
    logic [1:0] prev_src;

    logic       busy_en;
    int         busy_delay;
    int         busy_len;
    logic [1:0] prev_cmd;

    transport_cmd_arbiter #(
        .CMD_HOLD(5),
        .BUSY_TIMEOUT(64),
        .MAX_CTRL_RUN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_req(ctrl_req),
        .ctrl_cmd(ctrl_cmd),
        .ctrl_data(ctrl_data),
        .ctrl_ack(ctrl_ack),
        .audio_req(audio_req),
        .audio_cmd(audio_cmd),
        .audio_data(audio_data),
        .audio_ack(audio_ack),
        .tx_cmd(tx_cmd),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .active_src(active_src),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic reset_busy_model();
        busy_delay = 0;
        busy_len   = 0;
        tx_busy    = 1'b0;
        prev_cmd   = 2'b00;
    endtask

    // One clock: sample 1 time unit after the edge, update the busy model and monitors.
    // The busy model raises tx_busy 3 cycles after tx_cmd leaves 00 and holds it 10 cycles.
    task automatic step();
        @(posedge clk);
        #1;
        if (ctrl_ack) n_ctrl_ack++;
        if (audio_ack) n_audio_ack++;
        if (timeout_err) n_timeout++;
        if (ctrl_ack && audio_ack) n_both++;
        if (prev_src == 2'b00 && active_src != 2'b00) grant_log.push_back(active_src);
        prev_src = active_src;
        if (busy_en) begin
            if (busy_delay > 0) begin
                busy_delay--;
                if (busy_delay == 0) begin
                    tx_busy  = 1'b1;
                    busy_len = 10;
                end
            end else if (busy_len > 0) begin
                busy_len--;
                if (busy_len == 0) tx_busy = 1'b0;
            end else if (tx_cmd != 2'b00 && prev_cmd == 2'b00) begin
                busy_delay = 3;
            end
        end
        prev_cmd = tx_cmd;
    endtask

    task automatic apply_reset();
        ctrl_req  = 1'b0;
        audio_req = 1'b0;
        reset     = 1'b0;
        reset_busy_model();
        step();
        step();
        reset = 1'b1;
        step();
        n_ctrl_ack  = 0;
        n_audio_ack = 0;
        n_timeout   = 0;
        n_both      = 0;
        grant_log.delete();
    endtask

    // Runs until the first ack (bounded); offsets are in cycles from the first non-zero tx_cmd sample.
    task automatic apply_stimulus(input logic drop_on_issue, input int bound,
                                  output int start, output int hold, output logic [1:0] cmd_seen,
                                  output logic [15:0] data_seen, output int ack_off, output logic to_at_ack);
        logic found;
        found     = 1'b0;
        start     = -1;
        hold      = 0;
        cmd_seen  = 2'b00;
        data_seen = 16'h0000;
        ack_off   = -1;
        to_at_ack = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (tx_cmd != 2'b00) begin
                if (start < 0) begin
                    start     = i;
                    cmd_seen  = tx_cmd;
                    data_seen = tx_data;
                    if (drop_on_issue) begin
                        ctrl_req  = 1'b0;
                        audio_req = 1'b0;
                    end
                end
                hold++;
            end
            if (ctrl_ack || audio_ack) begin
                found     = 1'b1;
                ack_off   = (start < 0) ? -1 : i - start;
                to_at_ack = timeout_err;
            end
        end
    endtask

    int          start;
    int          hold;
    logic [1:0]  cmd_seen;
    logic [15:0] data_seen;
    int          ack_off;
    logic        to_at_ack;
    logic        saw_cmd;
    logic [1:0]  entry;
    logic [1:0]  exp_order[10];

    initial begin
        errors     = 0;
        checks     = 0;
        n_ctrl_ack = 0;
        n_audio_ack = 0;
        n_timeout  = 0;
        n_both     = 0;
        prev_src   = 2'b00;
        busy_en    = 1'b1;
        reset      = 1'b1;
        ctrl_req   = 1'b0;
        ctrl_cmd   = 2'b00;
        ctrl_data  = 16'h0000;
        audio_req  = 1'b0;
        audio_cmd  = 2'b00;
        audio_data = 16'h0000;
        reset_busy_model();
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        // Reset state
        #1 reset = 1'b0;
        #1;
        check_output("rst_tx_cmd", 32'(tx_cmd), 32'h0);
        check_output("rst_tx_data", 32'(tx_data), 32'h0);
        check_output("rst_active_src", 32'(active_src), 32'h0);
        check_output("rst_acks", 32'({ctrl_ack, audio_ack}), 32'h0);
        check_output("rst_timeout_err", 32'(timeout_err), 32'h0);
        apply_reset();

        // Single control op
        $display("[TB] single control op");
        ctrl_cmd  = 2'b01;
        ctrl_data = 16'hA3F1;
        ctrl_req  = 1'b1;
        apply_stimulus(1'b0, 40, start, hold, cmd_seen, data_seen, ack_off, to_at_ack);
        check_output("t1_start", 32'(start), 32'd0);
        check_output("t1_hold", 32'(hold), 32'd5);
        check_output("t1_cmd", 32'(cmd_seen), 32'h1);
        check_output("t1_data", 32'(data_seen), 32'hA3F1);
        check_output("t1_ack_off", 32'(ack_off), 32'd14);
        check_output("t1_timeout", 32'(to_at_ack), 32'd0);
        check_output("t1_src_at_ack", 32'(active_src), 32'h1);
        ctrl_req = 1'b0;
        step();
        check_output("t1_src_after", 32'(active_src), 32'h0);
        check_output("t1_ack_after", 32'(ctrl_ack), 32'h0);
        step();
        step();
        step();
        check_output("t1_ack_count", 32'(n_ctrl_ack), 32'd1);

        // Contention and starvation limit
        $display("[TB] contention");
        apply_reset();
        ctrl_cmd   = 2'b01;
        ctrl_data  = 16'h1111;
        audio_cmd  = 2'b10;
        audio_data = 16'h2222;
        ctrl_req   = 1'b1;
        audio_req  = 1'b1;
        for (int i = 0; i < 400 && (n_ctrl_ack + n_audio_ack) < 10; i++) begin
            step();
        end
        ctrl_req  = 1'b0;
        audio_req = 1'b0;
        step();
        step();
        step();
        check_output("t2_grants", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            entry = (i < grant_log.size()) ? grant_log[i] : 2'b00;
            check_output($sformatf("t2_grant%0d", i), 32'(entry), 32'(exp_order[i]));
        end
        check_output("t2_audio_acks", 32'(n_audio_ack), 32'd2);
        check_output("t2_ctrl_acks", 32'(n_ctrl_ack), 32'd8);
        check_output("t2_both_acks", 32'(n_both), 32'd0);

        // Busy timeout
        $display("[TB] timeout");
        apply_reset();
        busy_en    = 1'b0;
        tx_busy    = 1'b0;
        audio_cmd  = 2'b10;
        audio_data = 16'hBEEF;
        audio_req  = 1'b1;
        apply_stimulus(1'b0, 120, start, hold, cmd_seen, data_seen, ack_off, to_at_ack);
        check_output("t3_cmd", 32'(cmd_seen), 32'h2);
        check_output("t3_hold", 32'(hold), 32'd5);
        check_output("t3_ack_off", 32'(ack_off), 32'd64);
        check_output("t3_timeout_at_ack", 32'(to_at_ack), 32'd1);
        check_output("t3_audio_ack", 32'(audio_ack), 32'd1);
        audio_req = 1'b0;
        step();
        check_output("t3_timeout_count", 32'(n_timeout), 32'd1);
        busy_en   = 1'b1;
        ctrl_cmd  = 2'b11;
        ctrl_data = 16'h5A5A;
        ctrl_req  = 1'b1;
        apply_stimulus(1'b0, 40, start, hold, cmd_seen, data_seen, ack_off, to_at_ack);
        check_output("t3_next_cmd", 32'(cmd_seen), 32'h3);
        check_output("t3_next_hold", 32'(hold), 32'd5);
        check_output("t3_next_ack_off", 32'(ack_off), 32'd14);
        check_output("t3_next_timeout", 32'(to_at_ack), 32'd0);
        ctrl_req = 1'b0;
        step();

        // No-op command
        $display("[TB] no-op");
        apply_reset();
        ctrl_cmd  = 2'b00;
        ctrl_data = 16'hFFFF;
        ctrl_req  = 1'b1;
        step();
        check_output("t4_ack", 32'(ctrl_ack), 32'd1);
        check_output("t4_src", 32'(active_src), 32'h1);
        check_output("t4_timeout", 32'(timeout_err), 32'd0);
        ctrl_req = 1'b0;
        saw_cmd  = (tx_cmd != 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            if (tx_cmd != 2'b00) saw_cmd = 1'b1;
        end
        check_output("t4_tx_cmd_idle", 32'(saw_cmd), 32'd0);
        check_output("t4_tx_data", 32'(tx_data), 32'h0);
        check_output("t4_ack_count", 32'(n_ctrl_ack), 32'd1);
        check_output("t4_src_after", 32'(active_src), 32'h0);

        // Asynchronous reset in WAIT
        $display("[TB] reset mid-wait");
        apply_reset();
        ctrl_cmd  = 2'b01;
        ctrl_data = 16'h0F0F;
        ctrl_req  = 1'b1;
        for (int i = 0; i < 5 && tx_cmd == 2'b00; i++) begin
            step();
        end
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check_output("t5_pre_src", 32'(active_src), 32'h1);
        check_output("t5_pre_tx_cmd", 32'(tx_cmd), 32'h0);
        #3 reset = 1'b0;
        #1;
        check_output("t5_tx_cmd", 32'(tx_cmd), 32'h0);
        check_output("t5_tx_data", 32'(tx_data), 32'h0);
        check_output("t5_src", 32'(active_src), 32'h0);
        check_output("t5_acks", 32'({ctrl_ack, audio_ack, timeout_err}), 32'h0);
        reset_busy_model();
        step();
        step();
        check_output("t5_no_ack", 32'(n_ctrl_ack), 32'd0);
        #4 reset = 1'b1;
        apply_stimulus(1'b0, 40, start, hold, cmd_seen, data_seen, ack_off, to_at_ack);
        check_output("t5_restart", 32'(start), 32'd0);
        check_output("t5_hold", 32'(hold), 32'd5);
        check_output("t5_ack_off", 32'(ack_off), 32'd14);
        ctrl_req = 1'b0;
        step();

        // Request withdrawn during ISSUE
        $display("[TB] withdrawal");
        apply_reset();
        audio_cmd  = 2'b11;
        audio_data = 16'h1234;
        audio_req  = 1'b1;
        apply_stimulus(1'b1, 40, start, hold, cmd_seen, data_seen, ack_off, to_at_ack);
        check_output("t6_cmd", 32'(cmd_seen), 32'h3);
        check_output("t6_data", 32'(data_seen), 32'h1234);
        check_output("t6_hold", 32'(hold), 32'd5);
        check_output("t6_ack_off", 32'(ack_off), 32'd14);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check_output("t6_ack_count", 32'(n_audio_ack), 32'd1);
        check_output("t6_grants", 32'(grant_log.size()), 32'd1);
        check_output("t6_src_after", 32'(active_src), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
